// File: rtl/div_operand_guard.sv
// Issue stage for the iterative signed divider: buffers operand pairs, rejects zero divisors
// (and, with DIV_GUARD_MIN_DIVIDEND_EN, the most-negative dividend) and splits legal pairs into lhs/rhs.
module div_operand_guard #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [W-1:0]     div_lhs,
    output logic             div_lhs_vld,
    input  logic             div_lhs_rdy,
    output logic [W-1:0]     div_rhs,
    output logic             div_rhs_vld,
    input  logic             div_rhs_rdy,
    output logic             err_vld,
    input  logic             err_rdy,
    output logic [1:0]       err_code,
    output logic [W-1:0]     err_lhs,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] reject_cnt
);

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_LEGAL,
        HEAD_ZERO,
        HEAD_OVF
    } head_cls_t;

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] mem_a [2];
    logic [W-1:0] mem_b [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         lhs_sent;
    logic         rhs_sent;

    logic [W-1:0] head_a;
    logic [W-1:0] head_b;
    head_cls_t    head_cls;
    logic         push;
    logic         pop;
    logic         pop_legal;
    logic         pop_err;
    logic         lhs_hs;
    logic         rhs_hs;

    assign head_a = mem_a[rd_ptr];
    assign head_b = mem_b[rd_ptr];
    assign in_rdy = (count != 2'd2);
    assign push   = in_vld & in_rdy;

    always_comb begin
        head_cls = HEAD_LEGAL;
        if (count == 2'd0) begin
            head_cls = HEAD_EMPTY;
        end else if (head_b == '0) begin
            head_cls = HEAD_ZERO;
        end
`ifdef DIV_GUARD_MIN_DIVIDEND_EN
        else if (head_a == MIN_NEG) begin
            head_cls = HEAD_OVF;
        end
`endif
    end

    always_comb begin
        div_lhs     = '0;
        div_rhs     = '0;
        div_lhs_vld = 1'b0;
        div_rhs_vld = 1'b0;
        err_vld     = 1'b0;
        err_code    = 2'b00;
        err_lhs     = '0;
        unique case (head_cls)
            HEAD_LEGAL: begin
                div_lhs     = head_a;
                div_rhs     = head_b;
                div_lhs_vld = !lhs_sent;
                div_rhs_vld = !rhs_sent;
            end
            HEAD_ZERO: begin
                err_vld  = 1'b1;
                err_code = 2'b01;
                err_lhs  = head_a;
            end
            HEAD_OVF: begin
                err_vld  = 1'b1;
                err_code = 2'b10;
                err_lhs  = head_a;
            end
            default: ;
        endcase
    end

    // A legal pair retires once both halves are done, including handshakes in this same cycle.
    assign lhs_hs    = div_lhs_vld & div_lhs_rdy;
    assign rhs_hs    = div_rhs_vld & div_rhs_rdy;
    assign pop_legal = (head_cls == HEAD_LEGAL) & (lhs_sent | lhs_hs) & (rhs_sent | rhs_hs);
    assign pop_err   = err_vld & err_rdy;
    assign pop       = pop_legal | pop_err;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            lhs_sent   <= 1'b0;
            rhs_sent   <= 1'b0;
            issue_cnt  <= '0;
            reject_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
            if (pop_legal) begin
                lhs_sent  <= 1'b0;
                rhs_sent  <= 1'b0;
                issue_cnt <= issue_cnt + 1'b1;
            end else begin
                if (lhs_hs) lhs_sent <= 1'b1;
                if (rhs_hs) rhs_sent <= 1'b1;
            end
            if (pop_err) reject_cnt <= reject_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_div_operand_guard.sv
// Directed bench for div_operand_guard: queue-based reference model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_div_operand_guard;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_a, in_b;
    logic        in_vld, in_rdy;
    logic [7:0]  div_lhs, div_rhs, err_lhs;
    logic        div_lhs_vld, div_lhs_rdy, div_rhs_vld, div_rhs_rdy;
    logic        err_vld, err_rdy;
    logic [1:0]  err_code;
    logic [15:0] issue_cnt, reject_cnt;

    int total = 0;
    int bad   = 0;

    div_operand_guard #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_a(in_a), .in_b(in_b), .in_vld(in_vld), .in_rdy(in_rdy),
        .div_lhs(div_lhs), .div_lhs_vld(div_lhs_vld), .div_lhs_rdy(div_lhs_rdy),
        .div_rhs(div_rhs), .div_rhs_vld(div_rhs_vld), .div_rhs_rdy(div_rhs_rdy),
        .err_vld(err_vld), .err_rdy(err_rdy), .err_code(err_code), .err_lhs(err_lhs),
        .issue_cnt(issue_cnt), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

`ifdef DIV_GUARD_MIN_DIVIDEND_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    pair_t       q[$];
    bit          m_ls, m_rs, checking;
    logic [15:0] m_icnt, m_rcnt;

    logic [7:0]  e_lhs, e_rhs, e_elhs;
    logic        e_lvld, e_rvld, e_evld, e_inrdy, e_legal;
    logic [1:0]  e_code;

    function automatic void compute_exp();
        e_lhs = 8'h00; e_rhs = 8'h00; e_elhs = 8'h00;
        e_lvld = 1'b0; e_rvld = 1'b0; e_evld = 1'b0; e_code = 2'b00; e_legal = 1'b0;
        e_inrdy = (q.size() < 2);
        if (q.size() > 0) begin
            if (q[0].b == 8'h00) begin
                e_evld = 1'b1; e_code = 2'b01; e_elhs = q[0].a;
            end else if (OVF_EN && q[0].a == 8'h80) begin
                e_evld = 1'b1; e_code = 2'b10; e_elhs = q[0].a;
            end else begin
                e_legal = 1'b1;
                e_lhs = q[0].a; e_rhs = q[0].b;
                e_lvld = !m_ls; e_rvld = !m_rs;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each rising edge using its own view of the handshakes.
    initial begin
        bit do_push, lh, rh;
        checking = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_ls = 1'b0; m_rs = 1'b0; m_icnt = '0; m_rcnt = '0;
                checking = 1'b1;
            end else begin
                compute_exp();
                do_push = in_vld && (q.size() < 2);
                lh = e_lvld && div_lhs_rdy;
                rh = e_rvld && div_rhs_rdy;
                if (e_legal && (m_ls || lh) && (m_rs || rh)) begin
                    void'(q.pop_front());
                    m_ls = 1'b0; m_rs = 1'b0; m_icnt = m_icnt + 16'd1;
                end else if (e_legal) begin
                    m_ls = m_ls || lh; m_rs = m_rs || rh;
                end else if (e_evld && err_rdy) begin
                    void'(q.pop_front());
                    m_rcnt = m_rcnt + 16'd1;
                end
                if (do_push) q.push_back('{a: in_a, b: in_b});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                compute_exp();
                chk("in_rdy", in_rdy, e_inrdy);
                chk("div_lhs", div_lhs, e_lhs);
                chk("div_rhs", div_rhs, e_rhs);
                chk("div_lhs_vld", div_lhs_vld, e_lvld);
                chk("div_rhs_vld", div_rhs_vld, e_rvld);
                chk("err_vld", err_vld, e_evld);
                chk("err_code", err_code, e_code);
                chk("err_lhs", err_lhs, e_elhs);
                chk("issue_cnt", issue_cnt, m_icnt);
                chk("reject_cnt", reject_cnt, m_rcnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_a = '0; in_b = '0; in_vld = 1'b0;
        div_lhs_rdy = 1'b1; div_rhs_rdy = 1'b1; err_rdy = 1'b1;
        step(); step();
        rst = 1'b0;
        neg();
        chk("lit_reset_in_rdy", in_rdy, 1);
        chk("lit_reset_lvld", div_lhs_vld, 0);
        chk("lit_reset_icnt", issue_cnt, 0);

        // single pair
        in_a = 8'h14; in_b = 8'h03; in_vld = 1'b1;
        step(); in_vld = 1'b0;
        neg();
        chk("lit_single_lhs", div_lhs, 8'h14);
        chk("lit_single_rhs", div_rhs, 8'h03);
        chk("lit_single_vld", {div_lhs_vld, div_rhs_vld}, 2'b11);
        step(); neg();
        chk("lit_single_icnt", issue_cnt, 1);
        chk("lit_single_in_rdy", in_rdy, 1);

        // split acceptance
        div_rhs_rdy = 1'b0;
        in_a = 8'hEC; in_b = 8'h05; in_vld = 1'b1;
        step(); in_vld = 1'b0;
        step(); neg();
        chk("lit_split_lvld", div_lhs_vld, 0);
        chk("lit_split_rvld", div_rhs_vld, 1);
        step(); step();
        div_rhs_rdy = 1'b1;
        step(); neg();
        chk("lit_split_icnt", issue_cnt, 2);
        chk("lit_split_rvld_done", div_rhs_vld, 0);

        // zero divisor with err backpressure
        err_rdy = 1'b0;
        in_a = 8'h07; in_b = 8'h00; in_vld = 1'b1;
        step(); in_vld = 1'b0;
        step(); neg();
        chk("lit_zero_err", {err_vld, err_code, err_lhs}, {1'b1, 2'b01, 8'h07});
        chk("lit_zero_divvld", {div_lhs_vld, div_rhs_vld}, 2'b00);
        err_rdy = 1'b1;
        step(); neg();
        chk("lit_zero_rcnt", reject_cnt, 1);

        // backpressure / full
        div_lhs_rdy = 1'b0; div_rhs_rdy = 1'b0;
        in_vld = 1'b1; in_a = 8'h01; in_b = 8'h01;
        step(); in_a = 8'h02; in_b = 8'h02;
        step(); in_a = 8'h03; in_b = 8'h03;
        neg();
        chk("lit_full_in_rdy", in_rdy, 0);
        step();
        div_lhs_rdy = 1'b1; div_rhs_rdy = 1'b1;
        neg();
        chk("lit_full_head", div_lhs, 8'h01);
        step(); neg();
        chk("lit_full_second", div_lhs, 8'h02);
        chk("lit_full_in_rdy_back", in_rdy, 1);
        step(); in_vld = 1'b0;
        neg();
        chk("lit_full_third", div_lhs, 8'h03);
        step(); neg();
        chk("lit_full_icnt", issue_cnt, 5);

        // most-negative dividend
        in_a = 8'h80; in_b = 8'h02; in_vld = 1'b1;
        step(); in_vld = 1'b0;
        neg();
        if (OVF_EN) chk("lit_min_err", {err_vld, err_code, div_lhs_vld}, {1'b1, 2'b10, 1'b0});
        else        chk("lit_min_issue", {div_lhs_vld, div_lhs, div_rhs}, {1'b1, 8'h80, 8'h02});
        step(); neg();
        chk("lit_min_counts", {issue_cnt, reject_cnt}, OVF_EN ? {16'd5, 16'd2} : {16'd6, 16'd1});

        // reset mid-operation
        div_rhs_rdy = 1'b0;
        in_a = 8'h11; in_b = 8'h11; in_vld = 1'b1;
        step(); in_a = 8'h22; in_b = 8'h22;
        step(); in_vld = 1'b0;
        neg();
        chk("lit_mid_state", {in_rdy, div_lhs_vld, div_rhs_vld}, 3'b001);
        rst = 1'b1;
        step(); rst = 1'b0;
        neg();
        chk("lit_rst_vld", {div_lhs_vld, div_rhs_vld, err_vld, in_rdy}, 4'b0001);
        chk("lit_rst_cnts", {issue_cnt, reject_cnt}, 32'd0);
        div_rhs_rdy = 1'b1;
        in_a = 8'h44; in_b = 8'h04; in_vld = 1'b1;
        step(); in_vld = 1'b0;
        neg();
        chk("lit_fresh_vld", {div_lhs_vld, div_rhs_vld, div_lhs}, {2'b11, 8'h44});
        step(); neg();
        chk("lit_fresh_icnt", issue_cnt, 1);

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
